// File: rtl/bridge_pkg.sv
// Shared types for the slave-side NoC bridge: tag-entry states and flit layouts.
// Flit field widths follow the width localparams below; instances use matching widths.
package bridge_pkg;

    localparam int BR_ADDR_W  = 32;
    localparam int BR_DATA_W  = 32;
    localparam int BR_STRB_W  = BR_DATA_W / 8;
    localparam int BR_NODE_W  = 4;
    localparam int BR_MAX_OUT = 4;
    localparam int BR_TAG_W   = $clog2(BR_MAX_OUT);

    typedef enum logic [1:0] {
        ENT_FREE = 2'd0,
        ENT_PEND = 2'd1,
        ENT_DONE = 2'd2
    } ent_state_e;

    typedef struct packed {
        logic [BR_NODE_W-1:0] dest;
        logic [BR_NODE_W-1:0] src;
        logic [BR_TAG_W-1:0]  tag;
        logic                 we;
        logic [BR_ADDR_W-1:0] addr;
        logic [BR_DATA_W-1:0] wdata;
        logic [BR_STRB_W-1:0] wstrb;
    } tx_flit_t;

    typedef struct packed {
        logic [BR_TAG_W-1:0]  tag;
        logic [BR_DATA_W-1:0] data;
        logic                 err;
    } rx_flit_t;

endpackage

// File: rtl/bridge_slave_tag_table.sv
// Circular tag table: allocates tags in order, completes them from rx flits in any order,
// and retires them strictly in issue order. BRIDGE_SLAVE_TIMEOUT_EN adds per-entry timeouts.
module bridge_slave_tag_table
    import bridge_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       alloc_i,
    input  logic                       retire_i,
    input  logic                       rx_valid_i,
    input  rx_flit_t                   rx_i,
    output logic [$clog2(MAX_OUT)-1:0] wp_o,
    output logic                       full_o,
    output logic                       rsp_valid_o,
    output logic [DATA_W-1:0]          rsp_data_o,
    output logic                       rsp_err_o,
    output logic                       spurious_o
);

    localparam int TAG_W = $clog2(MAX_OUT);
    localparam int CNT_W = TAG_W + 1;

    ent_state_e        state_w [MAX_OUT];
    logic [DATA_W-1:0] data_w  [MAX_OUT];
    logic              err_w   [MAX_OUT];

    logic [TAG_W-1:0] wp_q, rp_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             spurious_q;
    logic             rx_hit;

    // Only a PEND entry may be completed; anything else is a stray flit.
    assign rx_hit = rx_valid_i && (state_w[rx_i.tag] == ENT_PEND);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUT; gi++) begin : g_entry
            ent_state_e        state_q;
            logic [DATA_W-1:0] data_q;
            logic              err_q;
            logic              expired;
            logic              sel_alloc, sel_rx, sel_retire;

            assign sel_alloc  = alloc_i && (wp_q == TAG_W'(gi));
            assign sel_rx     = rx_hit && (rx_i.tag == TAG_W'(gi));
            assign sel_retire = retire_i && (rp_q == TAG_W'(gi));

`ifdef BRIDGE_SLAVE_TIMEOUT_EN
            localparam int TMR_W = $clog2(TIMEOUT + 1);
            logic [TMR_W-1:0] timer_q;

            assign expired = (state_q == ENT_PEND) && (timer_q == TMR_W'(TIMEOUT));

            always_ff @(posedge clk) begin
                if (res) begin
                    timer_q <= '0;
                end else if (sel_alloc) begin
                    timer_q <= '0;
                end else if ((state_q == ENT_PEND) && !expired) begin
                    timer_q <= timer_q + TMR_W'(1);
                end
            end
`else
            assign expired = 1'b0;
`endif

            // A matching rx outranks a timeout expiring on the same edge.
            always_ff @(posedge clk) begin
                if (res) begin
                    state_q <= ENT_FREE;
                    data_q  <= '0;
                    err_q   <= 1'b0;
                end else if (sel_alloc) begin
                    state_q <= ENT_PEND;
                end else if (sel_rx) begin
                    state_q <= ENT_DONE;
                    data_q  <= rx_i.data;
                    err_q   <= rx_i.err;
                end else if (expired) begin
                    state_q <= ENT_DONE;
                    data_q  <= '0;
                    err_q   <= 1'b1;
                end else if (sel_retire) begin
                    state_q <= ENT_FREE;
                end
            end

            assign state_w[gi] = state_q;
            assign data_w[gi]  = data_q;
            assign err_w[gi]   = err_q;
        end
    endgenerate

    always_comb begin
        count_d = count_q + CNT_W'(alloc_i) - CNT_W'(retire_i);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (alloc_i) begin
                wp_q <= wp_q + TAG_W'(1);
            end
            if (retire_i) begin
                rp_q <= rp_q + TAG_W'(1);
            end
            count_q    <= count_d;
            spurious_q <= rx_valid_i && !rx_hit;
        end
    end

    assign wp_o        = wp_q;
    assign full_o      = (count_q == CNT_W'(MAX_OUT));
    assign rsp_valid_o = (state_w[rp_q] == ENT_DONE);
    assign rsp_data_o  = data_w[rp_q];
    assign rsp_err_o   = err_w[rp_q];
    assign spurious_o  = spurious_q;

endmodule

// File: rtl/bridge_slave_multi.sv
// Slave-side bus-to-NoC bridge: registers requests into tx flits, tracks them by tag and
// returns responses in issue order. Optional timeouts via BRIDGE_SLAVE_TIMEOUT_EN.
module bridge_slave_multi
    import bridge_pkg::*;
#(
    parameter int ID       = 0,
    parameter int SEND_TO  = 0,
    parameter int NUM_DEST = 1,
    parameter int MAX_OUT  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NODE_W   = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/8-1:0]        req_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       noc_tx_valid,
    input  logic                       noc_tx_ready,
    output logic [NODE_W-1:0]          noc_tx_dest,
    output logic [NODE_W-1:0]          noc_tx_src,
    output logic [$clog2(MAX_OUT)-1:0] noc_tx_tag,
    output logic                       noc_tx_we,
    output logic [ADDR_W-1:0]          noc_tx_addr,
    output logic [DATA_W-1:0]          noc_tx_wdata,
    output logic [DATA_W/8-1:0]        noc_tx_wstrb,
    input  logic                       noc_rx_valid,
    output logic                       noc_rx_ready,
    input  logic [$clog2(MAX_OUT)-1:0] noc_rx_tag,
    input  logic [DATA_W-1:0]          noc_rx_data,
    input  logic                       noc_rx_err,
    output logic                       spurious
);

    localparam int TAG_W  = $clog2(MAX_OUT);
    localparam int DSEL_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 0;

    logic             full;
    logic [TAG_W-1:0] wp;
    logic [NODE_W-1:0] dest;
    logic             accept, retire;
    tx_flit_t         tx_q, tx_d;
    logic             tx_valid_q, tx_valid_d;
    rx_flit_t         rx_flit;

    // Top address bits pick one of NUM_DEST consecutive nodes starting at SEND_TO.
    generate
        if (DSEL_W == 0) begin : g_single_dest
            assign dest = NODE_W'(SEND_TO);
        end else begin : g_multi_dest
            assign dest = NODE_W'(SEND_TO) + NODE_W'(req_addr[ADDR_W-1 -: DSEL_W]);
        end
    endgenerate

    assign req_ready = !full && (!tx_valid_q || noc_tx_ready);
    assign accept    = req_valid && req_ready;
    assign retire    = rsp_valid && rsp_ready;

    always_comb begin
        tx_d       = tx_q;
        tx_valid_d = tx_valid_q;
        if (accept) begin
            tx_d = '{dest: dest, src: NODE_W'(ID), tag: wp, we: req_we,
                     addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
            tx_valid_d = 1'b1;
        end else if (noc_tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            tx_q       <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_q       <= tx_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign noc_tx_valid = tx_valid_q;
    assign noc_tx_dest  = tx_q.dest;
    assign noc_tx_src   = tx_q.src;
    assign noc_tx_tag   = tx_q.tag;
    assign noc_tx_we    = tx_q.we;
    assign noc_tx_addr  = tx_q.addr;
    assign noc_tx_wdata = tx_q.wdata;
    assign noc_tx_wstrb = tx_q.wstrb;

    assign noc_rx_ready = 1'b1;
    assign rx_flit      = '{tag: noc_rx_tag, data: noc_rx_data, err: noc_rx_err};

    bridge_slave_tag_table #(
        .MAX_OUT (MAX_OUT),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_tag_table (
        .clk         (clk),
        .res         (res),
        .alloc_i     (accept),
        .retire_i    (retire),
        .rx_valid_i  (noc_rx_valid),
        .rx_i        (rx_flit),
        .wp_o        (wp),
        .full_o      (full),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .spurious_o  (spurious)
    );

endmodule

// File: tb/tb_bridge_slave_multi.sv
// Bench for bridge_slave_multi: directed scenarios followed by random traffic, all checked
// against an in-order transaction model. Timeout checks follow BRIDGE_SLAVE_TIMEOUT_EN.
module tb_bridge_slave_multi;

    localparam int ID_P      = 5;
    localparam int SEND_TO_P = 2;
    localparam int TMO       = 16;
`ifdef BRIDGE_SLAVE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        res;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        noc_tx_valid, noc_tx_ready, noc_tx_we;
    logic [3:0]  noc_tx_dest, noc_tx_src, noc_tx_wstrb;
    logic [1:0]  noc_tx_tag;
    logic [31:0] noc_tx_addr, noc_tx_wdata;
    logic        noc_rx_valid, noc_rx_ready, noc_rx_err;
    logic [1:0]  noc_rx_tag;
    logic [31:0] noc_rx_data;
    logic        spurious;

    int checks   = 0;
    int failures = 0;

    // Reference model: tags in issue order, per-tag status (0 free, 1 pending, 2 done).
    int          order[$];
    int          m_st   [4];
    logic [31:0] m_data [4];
    logic        m_err  [4];
    int          m_age  [4];
    int          m_wp;
    bit          m_spur;
    bit          m_txv;
    logic [3:0]  m_tx_dest, m_tx_wstrb;
    logic [1:0]  m_tx_tag;
    logic        m_tx_we;
    logic [31:0] m_tx_addr, m_tx_wdata;

    bridge_slave_multi #(
        .ID(ID_P), .SEND_TO(SEND_TO_P), .NUM_DEST(4), .MAX_OUT(4),
        .ADDR_W(32), .DATA_W(32), .NODE_W(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .noc_tx_valid(noc_tx_valid), .noc_tx_ready(noc_tx_ready),
        .noc_tx_dest(noc_tx_dest), .noc_tx_src(noc_tx_src), .noc_tx_tag(noc_tx_tag),
        .noc_tx_we(noc_tx_we), .noc_tx_addr(noc_tx_addr), .noc_tx_wdata(noc_tx_wdata),
        .noc_tx_wstrb(noc_tx_wstrb),
        .noc_rx_valid(noc_rx_valid), .noc_rx_ready(noc_rx_ready),
        .noc_rx_tag(noc_rx_tag), .noc_rx_data(noc_rx_data), .noc_rx_err(noc_rx_err),
        .spurious(spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        order.delete();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0; m_data[i] = '0; m_err[i] = 1'b0; m_age[i] = 0;
        end
        m_wp = 0; m_spur = 1'b0; m_txv = 1'b0;
    endtask

    task automatic idle();
        res = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; rsp_ready = 1'b0; noc_tx_ready = 1'b1;
        noc_rx_valid = 1'b0; noc_rx_tag = '0; noc_rx_data = '0; noc_rx_err = 1'b0;
    endtask

    // Check all outputs against the model, then advance one clock and update the model.
    task automatic cycle();
        bit exp_ready, exp_rv, acc, ret, hit, nspur;
        int rt;
        #1;
        exp_ready = (order.size() < 4) && (!m_txv || noc_tx_ready);
        exp_rv    = (order.size() > 0) && (m_st[order[0]] == 2);
        chk("req_ready", req_ready, exp_ready);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            chk("rsp_rdata", rsp_rdata, m_data[order[0]]);
            chk("rsp_err", rsp_err, m_err[order[0]]);
        end
        chk("tx_valid", noc_tx_valid, m_txv);
        if (m_txv) begin
            chk("tx_dest", noc_tx_dest, m_tx_dest);
            chk("tx_src", noc_tx_src, 4'(ID_P));
            chk("tx_tag", noc_tx_tag, m_tx_tag);
            chk("tx_we", noc_tx_we, m_tx_we);
            chk("tx_addr", noc_tx_addr, m_tx_addr);
            chk("tx_wdata", noc_tx_wdata, m_tx_wdata);
            chk("tx_wstrb", noc_tx_wstrb, m_tx_wstrb);
        end
        chk("spurious", spurious, m_spur);
        chk("rx_ready", noc_rx_ready, 1'b1);

        if (res) begin
            model_reset();
        end else begin
            acc   = req_valid && exp_ready;
            ret   = exp_rv && rsp_ready;
            rt    = int'(noc_rx_tag);
            hit   = noc_rx_valid && (m_st[rt] == 1);
            nspur = noc_rx_valid && !hit;
            if (TO_EN) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_st[i] == 1 && !(hit && i == rt)) begin
                        m_age[i]++;
                        if (m_age[i] == TMO + 1) begin
                            m_st[i] = 2; m_data[i] = '0; m_err[i] = 1'b1;
                        end
                    end
                end
            end
            if (hit) begin
                m_st[rt] = 2; m_data[rt] = noc_rx_data; m_err[rt] = noc_rx_err;
            end
            if (ret) begin
                m_st[order[0]] = 0;
                void'(order.pop_front());
            end
            if (acc) begin
                order.push_back(m_wp);
                m_st[m_wp] = 1; m_age[m_wp] = 0;
                m_txv      = 1'b1;
                m_tx_dest  = 4'((SEND_TO_P + int'(req_addr[31:30])) % 16);
                m_tx_tag   = 2'(m_wp);
                m_tx_we    = req_we;
                m_tx_addr  = req_addr;
                m_tx_wdata = req_wdata;
                m_tx_wstrb = req_wstrb;
                m_wp       = (m_wp + 1) % 4;
            end else if (noc_tx_ready) begin
                m_txv = 1'b0;
            end
            m_spur = nspur;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] tags_ooo [4];
        tags_ooo[0] = 2'd3; tags_ooo[1] = 2'd1; tags_ooo[2] = 2'd0; tags_ooo[3] = 2'd2;

        idle();
        res = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        res = 1'b0;
        #1;
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_tx_valid", noc_tx_valid, 1'b0);
        chk("reset_spurious", spurious, 1'b0);
        cycle();

        // Single read routed by the top address bits.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0000;
        cycle();
        req_valid = 1'b0;
        chk("s1_tx_dest", noc_tx_dest, 4'd3);
        chk("s1_tx_tag", noc_tx_tag, 2'd0);
        cycle();
        noc_rx_valid = 1'b1; noc_rx_tag = 2'd0; noc_rx_data = 32'hDEAD_BEEF;
        cycle();
        noc_rx_valid = 1'b0;
        chk("s1_rsp_valid", rsp_valid, 1'b1);
        chk("s1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("s1_rsp_err", rsp_err, 1'b0);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;

        // Fill the table, complete out of order, retire in order.
        res = 1'b1;
        cycle();
        res = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_we = i[0]; req_addr = $urandom;
            req_wdata = $urandom; req_wstrb = 4'($urandom);
            cycle();
        end
        req_valid = 1'b0;
        chk("s2_full_ready", req_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            noc_rx_valid = 1'b1; noc_rx_tag = tags_ooo[i];
            noc_rx_data = 32'hA000_0000 + 32'(tags_ooo[i]); noc_rx_err = 1'b0;
            cycle();
        end
        noc_rx_valid = 1'b0;
        chk("s2_rsp_valid", rsp_valid, 1'b1);
        chk("s2_first_rdata", rsp_rdata, 32'hA000_0000);

        // Full with a retire and a new request in the same cycle.
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h8000_0010; req_we = 1'b1;
        #1;
        chk("s3_ready_while_full", req_ready, 1'b0);
        cycle();
        rsp_ready = 1'b0;
        cycle();
        req_valid = 1'b0;
        chk("s3_new_tag_wrapped", noc_tx_tag, 2'd0);
        chk("s3_tx_valid", noc_tx_valid, 1'b1);
        chk("s3_full_again", req_ready, 1'b0);
        rsp_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("s3_drain_rdata", rsp_rdata, 32'hA000_0000 + 32'(k));
            cycle();
        end
        noc_rx_valid = 1'b1; noc_rx_tag = 2'd0; noc_rx_data = 32'h1234_5678;
        cycle();
        noc_rx_valid = 1'b0;
        cycle();
        rsp_ready = 1'b0;

        // Stray flit to a free entry.
        noc_rx_valid = 1'b1; noc_rx_tag = 2'd2; noc_rx_data = $urandom;
        cycle();
        noc_rx_valid = 1'b0;
        chk("s4_spurious_pulse", spurious, 1'b1);
        cycle();
        chk("s4_spurious_clear", spurious, 1'b0);
        chk("s4_rsp_valid", rsp_valid, 1'b0);

        // Reset with outstanding transactions.
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = $urandom;
            cycle();
        end
        req_valid = 1'b0;
        res = 1'b1;
        cycle();
        res = 1'b0;
        chk("s5_ready_after_reset", req_ready, 1'b1);
        chk("s5_rsp_after_reset", rsp_valid, 1'b0);
        noc_rx_valid = 1'b1; noc_rx_tag = 2'd1;
        cycle();
        noc_rx_valid = 1'b0;
        chk("s5_pre_reset_tag_spurious", spurious, 1'b1);

`ifdef BRIDGE_SLAVE_TIMEOUT_EN
        // Unanswered request times out 17 cycles after acceptance.
        cycle();
        req_valid = 1'b1; req_addr = 32'h0000_0100; req_we = 1'b0;
        cycle();
        req_valid = 1'b0;
        for (int i = 1; i < TMO + 1; i++) cycle();
        chk("s6_no_rsp_at_16", rsp_valid, 1'b0);
        cycle();
        chk("s6_rsp_at_17", rsp_valid, 1'b1);
        chk("s6_timeout_err", rsp_err, 1'b1);
        chk("s6_timeout_data", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
`endif

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            req_valid    = ($urandom_range(0, 9) < 5);
            req_we       = 1'($urandom);
            req_addr     = $urandom;
            req_wdata    = $urandom;
            req_wstrb    = 4'($urandom);
            rsp_ready    = ($urandom_range(0, 9) < 6);
            noc_tx_ready = ($urandom_range(0, 9) < 7);
            noc_rx_valid = ($urandom_range(0, 9) < 4);
            noc_rx_data  = $urandom;
            noc_rx_err   = ($urandom_range(0, 9) == 0);
            if (order.size() > 0 && $urandom_range(0, 9) < 8)
                noc_rx_tag = 2'(order[$urandom_range(0, order.size() - 1)]);
            else
                noc_rx_tag = 2'($urandom);
            res = ($urandom_range(0, 199) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bridge_slave_multi.md
BRIDGE_SLAVE_MULTI -- requirements
Module: bridge_slave_multi

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ID, 0: own NoC node id.
- SEND_TO, 0: base destination node.
- NUM_DEST, 1: destinations selectable by address (power of 2).
- MAX_OUT, 4: outstanding transactions (power of 2, >= 2).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- NODE_W, 4: node id width.
- TIMEOUT, 1024: timeout in cycles.
REQ-002 Derived: TAG_W = $clog2(MAX_OUT); DSEL_W = $clog2(NUM_DEST), or 0 when NUM_DEST = 1.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk in 1: the only clock.
- res in 1: synchronous, active-high reset.
- req_valid in 1, req_ready out 1: request handshake.
- req_we in 1: 1 = write.
- req_addr in ADDR_W: address.
- req_wdata in DATA_W, req_wstrb in DATA_W/8: write data and byte strobes.
- rsp_valid out 1, rsp_ready in 1: response handshake.
- rsp_rdata out DATA_W: read data.
- rsp_err out 1: error flag.
- noc_tx_valid out 1, noc_tx_ready in 1: outgoing flit handshake.
- noc_tx_dest out NODE_W, noc_tx_src out NODE_W, noc_tx_tag out TAG_W: flit routing and tag.
- noc_tx_we out 1, noc_tx_addr out ADDR_W, noc_tx_wdata out DATA_W, noc_tx_wstrb out DATA_W/8: flit payload.
- noc_rx_valid in 1, noc_rx_ready out 1: incoming flit handshake.
- noc_rx_tag in TAG_W, noc_rx_data in DATA_W, noc_rx_err in 1: incoming flit contents.
- spurious out 1: one-cycle pulse on an unmatched rx flit.

Function
REQ-004 A request SHALL be accepted when req_valid && req_ready, with req_ready = !full && (!noc_tx_valid || noc_tx_ready).
REQ-005 An accepted request SHALL appear on the registered noc_tx_* outputs one cycle later and hold stable until noc_tx_ready.
REQ-006 noc_tx_dest SHALL be SEND_TO + req_addr[ADDR_W-1 -: DSEL_W] (modulo 2^NODE_W), or SEND_TO when NUM_DEST = 1; noc_tx_src SHALL be ID.
REQ-007 The tag table SHALL be a MAX_OUT-entry circular buffer with alloc pointer wp, retire pointer rp and count; entry states are FREE, PEND and DONE.
REQ-008 Acceptance SHALL set entry[wp] FREE->PEND, drive noc_tx_tag = wp, and increment wp (wrapping at MAX_OUT); full = (count == MAX_OUT).
REQ-009 noc_rx_ready SHALL be constant 1.
REQ-010 An rx flit whose tag addresses a PEND entry SHALL store data and err and set the entry to DONE.
REQ-011 An rx flit whose tag addresses a FREE or DONE entry SHALL be dropped, and spurious SHALL pulse high for one cycle in the following cycle.
REQ-012 rsp_valid SHALL equal (entry[rp] == DONE), with rsp_rdata and rsp_err taken from entry[rp]; responses retire strictly in issue order even when rx arrives out of order.
REQ-013 On rsp_valid && rsp_ready, entry[rp] SHALL go to FREE and rp SHALL increment (wrapping).
REQ-014 Latency: rx arriving at cycle t for the rp entry SHALL give rsp_valid at t+1.
REQ-015 Alloc, rx-complete and retire in the same cycle SHALL all take effect; count changes by (alloc - retire).
REQ-016 An accept in the same cycle as a retire while full SHALL NOT occur, because req_ready uses the registered full.

Reset
REQ-017 While res is high at a clk edge, the block SHALL set all entries FREE, wp = rp = count = 0, and noc_tx_valid, rsp_valid, spurious and all timers to 0.
REQ-018 Reset mid-operation SHALL discard all outstanding transactions without generating responses; rx flits for pre-reset tags SHALL be flagged spurious.

Configuration
REQ-019 With BRIDGE_SLAVE_TIMEOUT_EN defined, each PEND entry SHALL run a counter of $clog2(TIMEOUT+1) bits, cleared on alloc.
REQ-020 With BRIDGE_SLAVE_TIMEOUT_EN defined, a PEND entry whose counter reaches TIMEOUT SHALL become DONE with err = 1 and data = 0; a later rx for that tag is spurious.
REQ-021 With BRIDGE_SLAVE_TIMEOUT_EN undefined, there SHALL be no counters and PEND entries wait indefinitely.
REQ-022 With BRIDGE_SLAVE_TIMEOUT_EN defined, a timeout expiring in the same cycle as a matching rx SHALL give the rx priority.

Structure
REQ-023 Package bridge_pkg SHALL hold the entry-state enum (FREE/PEND/DONE) and the tx and rx flit packed structs, parametrised by width localparams.
REQ-024 The tag table (entries, pointers, count, timers) SHALL be sub-module bridge_slave_tag_table; bridge_slave_multi holds the tx register, destination decode and glue.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single read, addr 0x4000_0000, NUM_DEST = 4, SEND_TO = 2 -> noc_tx_dest = 3, tag 0; rx tag 0 data 0xDEADBEEF -> next cycle rsp_valid, rdata 0xDEADBEEF, err 0.
- 4 requests with MAX_OUT = 4 -> req_ready = 0 after the 4th; rx in tag order 3,1,0,2 -> responses in order 0,1,2,3 with matching data.
- Full, and in the same cycle a retire plus new req_valid -> accepted the next cycle; count stays 4; new tag = 0 (wrapped).
- rx tag 2 while entry 2 is FREE -> spurious pulses one cycle; table unchanged.
- res asserted with 3 outstanding -> req_ready = 1 next cycle, rsp_valid = 0; rx tag 1 -> spurious.
- BRIDGE_SLAVE_TIMEOUT_EN with TIMEOUT = 16, no rx -> rsp_valid with err = 1 exactly 17 cycles after acceptance.
